cpu_multicycle: RTL and testbench

Parametrised multi-cycle RV32I-subset core that succeeds the single-cycle cpu top. One shared ALU path is sequenced by an explicit state machine. Instruction fetch goes through a req/valid handshake, so wait-state memories are supported. Adds a data memory (lw/sw), jal/lui, halt detection, illegal-opcode trapping and a retired-instruction counter, while keeping the a0 debug output.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/cpu_mc_regfile.sv | 33 +++
 rtl/cpu_multicycle.sv | 212 +++++++++++++++++++++
 tb/tb_cpu_multicycle.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset core: opcodes, FSM states,
// ALU controls and the self-jump encoding that stops the core.
package cpu_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // jal x0,0 is treated as a halt rather than an infinite loop
  localparam logic [31:0] HALT_INSTR = 32'h0000006F;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
endpackage

// File: rtl/cpu_mc_regfile.sv
// Register file: two async read ports, one write port, x0 hard-wired to zero,
// with a live tap of x10 for debug.
module cpu_mc_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] ra1,
  input  logic [REG_ADDR_WIDTH-1:0] ra2,
  input  logic                      we,
  input  logic [REG_ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0]     wd,
  output logic [DATA_WIDTH-1:0]     rd1,
  output logic [DATA_WIDTH-1:0]     rd2,
  output logic [DATA_WIDTH-1:0]     a0
);
  localparam int NREGS = 2**REG_ADDR_WIDTH;

  logic [NREGS-1:0][DATA_WIDTH-1:0] regs;

  // regs[0] is only ever reset, so it reads back as zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 regs     <= '0;
    else if (we && wa != '0) regs[wa] <= wd;
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
  assign a0  = regs[10];
endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32I-subset core: one shared ALU sequenced through
// FETCH/DECODE/EXEC/MEM/WB, handshaked fetch, word data memory, halt/trap.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    REG_ADDR_WIDTH  = 5,
  parameter int                    DMEM_ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_PC        = '0,
  parameter int                    CNT_WIDTH       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  instr_req,
  output logic [DATA_WIDTH-1:0] instr_addr,
  input  logic [31:0]           instr_rdata,
  input  logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] a0,
  output logic                  halted,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  retired
);
  localparam int             DW   = DATA_WIDTH;
  localparam logic [DW-1:0]  FOUR = DW'(4);

  state_t              state, nxt;
  alu_op_t             alu_op;
  logic [31:0]         ir;
  logic [DW-1:0]       pc, a, b, imm, alu_out, mdr;
  logic [DW-1:0]       op_b, alu_res, rd1, rd2, wd;
  logic signed [31:0]  imm32;
  logic [6:0]          opc, f7;
  logic [2:0]          f3;
  logic                legal, taken, is_halt, rf_we, retire;
  logic                halted_q, illegal_q;
  logic [DW-1:0]       dmem [2**DMEM_ADDR_WIDTH];
  logic [DMEM_ADDR_WIDTH-1:0] widx;

  assign opc     = ir[6:0];
  assign f3      = ir[14:12];
  assign f7      = ir[31:25];
  assign is_halt = (ir == HALT_INSTR);
  assign taken   = (a == b) ^ f3[0];
  assign widx    = alu_out[DMEM_ADDR_WIDTH+1:2];

  always_comb begin
    case (opc)
      OP_STORE:  imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH: imm32 = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_JAL:    imm32 = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      OP_LUI:    imm32 = {ir[31:12], 12'b0};
      default:   imm32 = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  always_comb begin
    case (opc)
      OP_R:              legal = (f7 == 7'h00 && (f3 == 3'b000 || f3 == 3'b111 ||
                                                  f3 == 3'b110 || f3 == 3'b010)) ||
                                 (f7 == 7'h20 && f3 == 3'b000);
      OP_I:              legal = (f3 == 3'b000);
      OP_LOAD, OP_STORE: legal = (f3 == 3'b010);
      OP_BRANCH:         legal = (f3[2:1] == 2'b00);
      OP_JAL, OP_LUI:    legal = 1'b1;
      default:           legal = 1'b0;
    endcase
  end

  // Non-R opcodes (addi, address generation) all use add with the immediate
  always_comb begin
    alu_op = ALU_ADD;
    if (opc == OP_R) begin
      case (f3)
        3'b111:  alu_op = ALU_AND;
        3'b110:  alu_op = ALU_OR;
        3'b010:  alu_op = ALU_SLT;
        default: alu_op = f7[5] ? ALU_SUB : ALU_ADD;
      endcase
    end
  end

  assign op_b = (opc == OP_R) ? b : imm;

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_res = a - op_b;
      ALU_AND: alu_res = a & op_b;
      ALU_OR:  alu_res = a | op_b;
      ALU_SLT: alu_res = {{(DW-1){1'b0}}, ($signed(a) < $signed(op_b))};
      default: alu_res = a + op_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= nxt;
  end

  always_comb begin
    nxt       = state;
    instr_req = 1'b0;
    rf_we     = 1'b0;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        instr_req = rst;
        if (instr_valid) nxt = DECODE;
      end
      DECODE: nxt = legal ? EXEC : HALT;
      EXEC: begin
        case (opc)
          OP_BRANCH: begin
            nxt    = FETCH;
            retire = 1'b1;
          end
          OP_JAL: begin
            nxt    = is_halt ? HALT : WB;
            retire = is_halt;
          end
          OP_LOAD, OP_STORE: nxt = MEM;
          default:           nxt = WB;
        endcase
      end
      MEM: begin
        nxt    = (opc == OP_STORE) ? FETCH : WB;
        retire = (opc == OP_STORE);
      end
      WB: begin
        nxt    = FETCH;
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      default: nxt = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      imm       <= '0;
      alu_out   <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired   <= '0;
    end else begin
      if (retire) retired <= retired + 1'b1;
      case (state)
        FETCH: if (instr_valid) ir <= instr_rdata;
        DECODE: begin
          a   <= rd1;
          b   <= rd2;
          imm <= DW'(imm32);
          if (!legal) begin
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
          end
        end
        EXEC: begin
          case (opc)
            OP_BRANCH: pc <= taken ? pc + imm : pc + FOUR;
            OP_JAL: begin
              if (is_halt) halted_q <= 1'b1;
              else begin
                alu_out <= pc + FOUR;
                pc      <= pc + imm;
              end
            end
            OP_LUI:  alu_out <= imm;
            default: alu_out <= alu_res;
          endcase
        end
        MEM: if (opc == OP_STORE) pc <= pc + FOUR;
        WB:  if (opc != OP_JAL)   pc <= pc + FOUR;
        default: ;
      endcase
    end
  end

  // Data memory is not reset; an async reset forces state to FETCH, so no store
  // can land on the edge where reset is active.
  always_ff @(posedge clk) begin
    if (state == MEM) begin
      if (opc == OP_STORE) dmem[widx] <= b;
      mdr <= dmem[widx];
    end
  end

  assign wd = (opc == OP_LOAD) ? mdr : alu_out;

  cpu_mc_regfile #(
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (ir[15 +: REG_ADDR_WIDTH]),
    .ra2 (ir[20 +: REG_ADDR_WIDTH]),
    .we  (rf_we),
    .wa  (ir[7 +: REG_ADDR_WIDTH]),
    .wd  (wd),
    .rd1 (rd1),
    .rd2 (rd2),
    .a0  (a0)
  );

  assign instr_addr = pc;
  assign halted     = halted_q  | (state == DECODE && !legal);
  assign illegal    = illegal_q | (state == DECODE && !legal);
endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: instruction memory responder with programmable
// wait states, a0-at-retirement scoreboard, and directed timing checks.
module tb_cpu_multicycle;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req, instr_valid = 1'b0;
  logic [31:0] instr_addr, instr_rdata = '0, a0, retired;
  logic        halted, illegal;

  logic [31:0] imem [64];
  logic [31:0] exp_a0 [$];
  logic [31:0] last_ret = '0;
  int          fetch_wait = 0, wcnt = 0;
  int          checks = 0, fails = 0;

  always #5 clk = ~clk;

  cpu_multicycle #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .DMEM_ADDR_WIDTH(8),
    .RESET_PC(32'h0), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_rdata(instr_rdata), .instr_valid(instr_valid), .a0(a0),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] i_enc(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [31:0] v = imm;
    return {v[11:0], 5'(rs1), f3, 5'(rd), op};
  endfunction
  function automatic logic [31:0] r_enc(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] s_enc(input int imm, input int rs2, input int rs1);
    logic [31:0] v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_enc(input int imm, input int rs2, input int rs1,
                                        input logic [2:0] f3);
    logic [31:0] v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] j_enc(input int imm, input int rd);
    logic [31:0] v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
  endfunction
  function automatic logic [31:0] u_enc(input int imm20, input int rd);
    logic [31:0] v = imm20;
    return {v[19:0], 5'(rd), 7'h37};
  endfunction
  function automatic logic [31:0] addi(input int imm, input int rs1, input int rd);
    return i_enc(imm, rs1, 3'b000, rd, 7'h13);
  endfunction

  // Fetch responder: valid after fetch_wait cycles of instr_req
  initial forever begin
    @(negedge clk);
    if (instr_req && wcnt >= fetch_wait) begin
      instr_valid = 1'b1;
      instr_rdata = imem[instr_addr[7:2]];
      wcnt        = 0;
    end else begin
      instr_valid = 1'b0;
      instr_rdata = '0;
      wcnt        = instr_req ? wcnt + 1 : 0;
    end
  end

  // Scoreboard: every retirement pops the expected a0 value
  initial forever begin
    @(negedge clk);
    if (!rst) last_ret = retired;
    else if (retired != last_ret) begin
      chk("retire_step", 64'(retired - last_ret), 1);
      if (exp_a0.size() == 0) chk("sb_pending", exp_a0.size(), 1);
      else                    chk("a0_at_retire", a0, exp_a0.pop_front());
      last_ret = retired;
    end
  end

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_prog();
    rst = 1'b0;
    exp_a0.delete();
    for (int i = 0; i < 64; i++) imem[i] = j_enc(0, 0);
  endtask

  // Leaves the bench at the negedge inside cycle 1 after release
  task automatic start(input int w);
    fetch_wait = w;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_to_halt(input int max);
    int n = 0;
    while (!halted && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", halted, 1);
    adv(2);
    chk("sb_drain", exp_a0.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_req", instr_req, 0);
    chk("rst_pc", instr_addr, 0);
    chk("rst_a0", a0, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);

    // addi/addi, zero-wait fetch
    clear_prog();
    imem[0] = addi(5, 0, 10);
    imem[1] = addi(-7, 10, 10);
    exp_a0.push_back(32'd5); exp_a0.push_back(32'hFFFF_FFFE); exp_a0.push_back(32'hFFFF_FFFE);
    start(0);
    chk("t1_req_c1", instr_req, 1);
    chk("t1_pc_c1", instr_addr, 0);
    adv(7);
    chk("t1_a0_c7", a0, 5);
    adv(1);
    chk("t1_a0_c8", a0, 32'hFFFF_FFFE);
    chk("t1_ret_c8", retired, 2);
    run_to_halt(50);
    chk("t1_illegal", illegal, 0);

    // three fetch wait states
    clear_prog();
    imem[0] = addi(1, 0, 10);
    exp_a0.push_back(32'd1); exp_a0.push_back(32'd1);
    start(3);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t2_req_held_c%0d", k), instr_req, 1);
      adv(1);
    end
    chk("t2_req_drop", instr_req, 0);
    adv(2);
    chk("t2_a0_c6", a0, 0);
    adv(1);
    chk("t2_a0_c7", a0, 1);
    chk("t2_ret_c7", retired, 1);
    run_to_halt(100);

    // lui/addi, sw, lw (5 cycles), add, aliased unaligned lw
    clear_prog();
    imem[0] = u_enc(1, 10);
    imem[1] = addi(32'h234, 10, 10);
    imem[2] = s_enc(8, 10, 0);
    imem[3] = i_enc(8, 0, 3'b010, 11, 7'h03);
    imem[4] = r_enc(7'h00, 11, 11, 3'b000, 10);
    imem[5] = i_enc(1034, 0, 3'b010, 10, 7'h03);
    exp_a0 = '{32'h1000, 32'h1234, 32'h1234, 32'h1234, 32'h2468, 32'h1234, 32'h1234};
    start(0);
    adv(16);
    chk("t3_ret_c16", retired, 3);
    adv(1);
    chk("t3_ret_c17", retired, 4);
    run_to_halt(100);
    chk("t3_a0_final", a0, 32'h1234);

    // countdown loop ending in jal x0,0
    clear_prog();
    imem[0] = addi(3, 0, 10);
    imem[1] = addi(-1, 10, 10);
    imem[2] = b_enc(-4, 0, 10, 3'b001);
    imem[3] = j_enc(0, 0);
    exp_a0 = '{32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0};
    start(0);
    run_to_halt(200);
    chk("t4_a0", a0, 0);
    chk("t4_illegal", illegal, 0);
    chk("t4_retired", retired, 8);
    for (int k = 0; k < 4; k++) begin
      adv(1);
      chk("t4_req_idle", instr_req, 0);
    end
    chk("t4_ret_frozen", retired, 8);

    // jal skipping a trap word, then R-type ops and an x0 write
    clear_prog();
    imem[0]  = j_enc(8, 10);
    imem[1]  = 32'h0000_007F;
    imem[2]  = addi(-3, 0, 1);
    imem[3]  = addi(5, 0, 2);
    imem[4]  = r_enc(7'h00, 2, 1, 3'b010, 10);
    imem[5]  = r_enc(7'h20, 2, 1, 3'b000, 10);
    imem[6]  = r_enc(7'h00, 2, 1, 3'b111, 10);
    imem[7]  = r_enc(7'h00, 2, 1, 3'b110, 10);
    imem[8]  = r_enc(7'h00, 1, 2, 3'b010, 10);
    imem[9]  = r_enc(7'h00, 2, 2, 3'b000, 0);
    imem[10] = r_enc(7'h00, 2, 0, 3'b000, 10);
    exp_a0 = '{32'd4, 32'd4, 32'd4, 32'd1, 32'hFFFF_FFF8, 32'd5, 32'hFFFF_FFFD,
               32'd0, 32'd0, 32'd5, 32'd5};
    start(0);
    run_to_halt(300);
    chk("t5_illegal", illegal, 0);
    chk("t5_retired", retired, 11);

    // illegal opcode in the second instruction
    clear_prog();
    imem[0] = addi(1, 0, 10);
    imem[1] = 32'h0000_007F;
    exp_a0.push_back(32'd1);
    start(0);
    adv(4);
    chk("t6_halted_fetch", halted, 0);
    adv(1);
    chk("t6_halted_decode", halted, 1);
    chk("t6_illegal_decode", illegal, 1);
    adv(3);
    chk("t6_retired", retired, 1);
    chk("t6_pc", instr_addr, 4);
    chk("t6_req", instr_req, 0);
    chk("t6_halted_hold", halted, 1);
    run_to_halt(10);

    // unsupported funct3 on an R-type opcode
    clear_prog();
    imem[0] = r_enc(7'h00, 2, 1, 3'b001, 10);
    start(0);
    run_to_halt(20);
    chk("t7_illegal", illegal, 1);
    chk("t7_retired", retired, 0);

    // reset asserted during EXEC aborts the instruction
    clear_prog();
    imem[0] = addi(9, 0, 10);
    exp_a0.push_back(32'd9); exp_a0.push_back(32'd9);
    start(0);
    adv(2);
    rst = 1'b0;
    #1;
    chk("t8_rst_req", instr_req, 0);
    chk("t8_rst_pc", instr_addr, 0);
    chk("t8_rst_ret", retired, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("t8_no_write", a0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t8_rel_req", instr_req, 1);
    chk("t8_rel_pc", instr_addr, 0);
    chk("t8_rel_a0", a0, 0);
    run_to_halt(50);
    chk("t8_a0", a0, 9);
    chk("t8_retired", retired, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
